// File: rtl/function_arbiter_pkg.sv
// Shared types for function_arbiter: FSM state encoding and pointer-width helper.
// The encoding localparams are visible to the bench as well as the RTL.
package function_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_ACK   = 2'd2;
    localparam logic [1:0] ST_CLEAR = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        GRANT = ST_GRANT,
        ACK   = ST_ACK,
        CLEAR = ST_CLEAR
    } state_t;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/function_arbiter_rr_picker.sv
// Combinational round-robin picker: one-hot winner is the first set request
// at or above ptr, wrapping to bit 0 when nothing at or above ptr is set.
module rr_picker
    import function_arbiter_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = ptr_width(N)
) (
    input  logic [N-1:0]  reqs,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          valid
);

    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!valid && reqs[j] && (j >= int'(ptr))) begin
                grant[j] = 1'b1;
                valid    = 1'b1;
            end
        end
        // Second pass covers the wrapped-around part below ptr.
        for (int j = 0; j < N; j++) begin
            if (!valid && reqs[j] && (j < int'(ptr))) begin
                grant[j] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/function_arbiter.sv
// Round-robin arbiter sharing one sets/fin/clr function unit among N 4-phase requesters.
// Optional GRANT watchdog with sticky err is enabled by defining FUNCTION_ARBITER_TIMEOUT_EN.
module function_arbiter
    import function_arbiter_pkg::*;
#(
    parameter int N       = 2,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] reqs,
    output logic [N-1:0] acks,
    output logic [N-1:0] sets,
    input  logic         fin,
    output logic         clr,
    output logic         busy,
    output logic         err
);

    localparam int PW = ptr_width(N);

    state_t        state, state_d;
    logic [PW-1:0] ptr, ptr_d;
    logic [PW-1:0] next_ptr, next_ptr_d;
    logic [PW-1:0] pick_next;
    logic [N-1:0]  win, win_d;
    logic [N-1:0]  pick;
    logic          pick_valid;
    logic [N-1:0]  acks_d, sets_d;
    logic          clr_d, busy_d;
    logic          finish;

    rr_picker #(.N(N), .PW(PW)) u_picker (
        .reqs  (reqs),
        .ptr   (ptr),
        .grant (pick),
        .valid (pick_valid)
    );

    // Pointer value to adopt once this winner's transaction completes.
    always_comb begin
        pick_next = '0;
        for (int j = 0; j < N; j++) begin
            if (pick[j]) pick_next = (j == N - 1) ? '0 : PW'(j + 1);
        end
    end

`ifdef FUNCTION_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt, cnt_d;
    logic          err_d;
`endif

    always_comb begin
        state_d    = state;
        ptr_d      = ptr;
        next_ptr_d = next_ptr;
        win_d      = win;
        acks_d     = acks;
        sets_d     = sets;
        clr_d      = 1'b0;
        finish     = 1'b0;
`ifdef FUNCTION_ARBITER_TIMEOUT_EN
        cnt_d      = cnt;
        err_d      = err;
`endif
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_d    = GRANT;
                    win_d      = pick;
                    next_ptr_d = pick_next;
                    sets_d     = pick;
`ifdef FUNCTION_ARBITER_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            GRANT: begin
                finish = fin;
`ifdef FUNCTION_ARBITER_TIMEOUT_EN
                cnt_d = cnt + 1'b1;
                // A stalled unit is treated as done so the requester still gets its ack.
                if (!fin && (cnt == CW'(TIMEOUT - 1))) begin
                    finish = 1'b1;
                    err_d  = 1'b1;
                end
`endif
                if (finish) begin
                    sets_d  = '0;
                    acks_d  = win;
                    state_d = ACK;
                end
            end
            ACK: begin
                if ((reqs & win) == '0) begin
                    acks_d  = '0;
                    clr_d   = 1'b1;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                ptr_d   = next_ptr;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            next_ptr <= '0;
            win      <= '0;
            acks     <= '0;
            sets     <= '0;
            clr      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            ptr      <= ptr_d;
            next_ptr <= next_ptr_d;
            win      <= win_d;
            acks     <= acks_d;
            sets     <= sets_d;
            clr      <= clr_d;
            busy     <= busy_d;
        end
    end

`ifdef FUNCTION_ARBITER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            cnt <= cnt_d;
            err <= err_d;
        end
    end
`else
    // Without the watchdog err is permanently low; TIMEOUT only matters with it.
    assign err = 1'b0 && (TIMEOUT > 0);
`endif

endmodule

// File: tb/tb_function_arbiter.sv
// Directed self-checking bench for function_arbiter: an N=2 and an N=4 (TIMEOUT=8) instance.
// Covers FUNCTION_ARBITER_TIMEOUT_EN both defined and undefined.
module tb_function_arbiter;
    import function_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] reqs2, acks2, sets2;
    logic       fin2, clr2, busy2, err2;
    logic [3:0] reqs4, acks4, sets4;
    logic       fin4, clr4, busy4, err4;

    int numChecks = 0;
    int numFails  = 0;

    always #5 clk = ~clk;

    function_arbiter #(.N(2)) dut2 (
        .clk (clk), .rst (rst), .reqs (reqs2), .acks (acks2), .sets (sets2),
        .fin (fin2), .clr (clr2), .busy (busy2), .err (err2)
    );

    function_arbiter #(.N(4), .TIMEOUT(8)) dut4 (
        .clk (clk), .rst (rst), .reqs (reqs4), .acks (acks4), .sets (sets4),
        .fin (fin4), .clr (clr4), .busy (busy4), .err (err4)
    );

    // Drive both instances' inputs, then advance one clock and settle past the edge.
    task automatic applyStimulus(input logic [3:0] r4, input logic f4,
                                 input logic [1:0] r2, input logic f2);
        reqs4 = r4;
        fin4  = f4;
        reqs2 = r2;
        fin2  = f2;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        numChecks++;
        assert (observed === expected)
        else begin
            numFails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One complete N=4 transaction with immediate fin; reqsAfter is presented from CLEAR on.
    task automatic serveFour(input logic [3:0] reqsVal, input logic [3:0] expWin,
                             input logic [3:0] reqsAfter);
        applyStimulus(reqsVal, 1'b0, 2'b00, 1'b0);
        checkOutput("n4_sets_grant", 32'(sets4), 32'(expWin));
        checkOutput("n4_acks_grant", 32'(acks4), 32'h0);
        checkOutput("n4_busy_grant", 32'(busy4), 32'h1);
        applyStimulus(reqsVal, 1'b1, 2'b00, 1'b0);
        checkOutput("n4_acks_ack", 32'(acks4), 32'(expWin));
        checkOutput("n4_sets_ack", 32'(sets4), 32'h0);
        applyStimulus(reqsVal & ~expWin, 1'b0, 2'b00, 1'b0);
        checkOutput("n4_clr_pulse", 32'(clr4), 32'h1);
        checkOutput("n4_acks_clear", 32'(acks4), 32'h0);
        applyStimulus(reqsAfter, 1'b0, 2'b00, 1'b0);
        checkOutput("n4_clr_single", 32'(clr4), 32'h0);
        checkOutput("n4_busy_idle", 32'(busy4), 32'h0);
    endtask

    initial begin
        logic [3:0] order [5];
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset state of both instances.
        rst = 1'b1;
        applyStimulus(4'b0000, 1'b0, 2'b00, 1'b0);
        applyStimulus(4'b0000, 1'b0, 2'b00, 1'b0);
        checkOutput("rst_acks2", 32'(acks2), 32'h0);
        checkOutput("rst_sets2", 32'(sets2), 32'h0);
        checkOutput("rst_clr2",  32'(clr2),  32'h0);
        checkOutput("rst_busy2", 32'(busy2), 32'h0);
        checkOutput("rst_err2",  32'(err2),  32'h0);
        checkOutput("rst_acks4", 32'(acks4), 32'h0);
        checkOutput("rst_sets4", 32'(sets4), 32'h0);
        checkOutput("rst_err4",  32'(err4),  32'h0);
        rst = 1'b0;

        // N=2: request 0, fin two cycles after sets, fin left high through CLEAR.
        applyStimulus(4'b0000, 1'b0, 2'b01, 1'b0);
        checkOutput("n2_sets_rise", 32'(sets2), 32'h1);
        checkOutput("n2_busy_rise", 32'(busy2), 32'h1);
        checkOutput("n2_acks_none", 32'(acks2), 32'h0);
        applyStimulus(4'b0000, 1'b0, 2'b01, 1'b0);
        checkOutput("n2_sets_hold", 32'(sets2), 32'h1);
        applyStimulus(4'b0000, 1'b0, 2'b01, 1'b1);
        checkOutput("n2_acks_on",   32'(acks2), 32'h1);
        checkOutput("n2_sets_off",  32'(sets2), 32'h0);
        applyStimulus(4'b0000, 1'b0, 2'b01, 1'b1);
        checkOutput("n2_acks_hold", 32'(acks2), 32'h1);
        checkOutput("n2_clr_wait",  32'(clr2),  32'h0);
        applyStimulus(4'b0000, 1'b0, 2'b00, 1'b1);
        checkOutput("n2_clr_pulse", 32'(clr2),  32'h1);
        checkOutput("n2_acks_off",  32'(acks2), 32'h0);
        checkOutput("n2_busy_clr",  32'(busy2), 32'h1);
        applyStimulus(4'b0000, 1'b0, 2'b00, 1'b1);
        checkOutput("n2_clr_once",  32'(clr2),  32'h0);
        checkOutput("n2_busy_low",  32'(busy2), 32'h0);
        // Pointer moved to 1, so requester 1 wins a tie.
        applyStimulus(4'b0000, 1'b0, 2'b11, 1'b0);
        checkOutput("n2_ptr_sets",  32'(sets2), 32'h2);
        applyStimulus(4'b0000, 1'b0, 2'b11, 1'b1);
        checkOutput("n2_ptr_acks",  32'(acks2), 32'h2);
        applyStimulus(4'b0000, 1'b0, 2'b00, 1'b0);
        checkOutput("n2_clr2",      32'(clr2),  32'h1);
        applyStimulus(4'b0000, 1'b0, 2'b00, 1'b0);
        checkOutput("n2_idle2",     32'(busy2), 32'h0);

        // N=4: all requests held; order must be 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            serveFour(4'b1111, order[k], (k == 4) ? 4'b0000 : 4'b1111);
        end

        // Pointer 1: winner 2 moves it to 3, then 0101 wraps to 0, then ptr=1 picks 2.
        serveFour(4'b0100, 4'b0100, 4'b0000);
        serveFour(4'b0101, 4'b0001, 4'b0000);
        serveFour(4'b0101, 4'b0100, 4'b0000);

        // Reset while acking requester 1 (ptr=3 picks 1 from 0010).
        applyStimulus(4'b0010, 1'b0, 2'b00, 1'b0);
        checkOutput("rst_mid_sets", 32'(sets4), 32'h2);
        applyStimulus(4'b0010, 1'b1, 2'b00, 1'b0);
        checkOutput("rst_mid_acks", 32'(acks4), 32'h2);
        rst = 1'b1;
        applyStimulus(4'b0010, 1'b0, 2'b00, 1'b0);
        checkOutput("rst_mid_acks0", 32'(acks4), 32'h0);
        checkOutput("rst_mid_sets0", 32'(sets4), 32'h0);
        checkOutput("rst_mid_clr0",  32'(clr4),  32'h0);
        checkOutput("rst_mid_busy0", 32'(busy4), 32'h0);
        rst = 1'b0;
        applyStimulus(4'b0000, 1'b0, 2'b00, 1'b0);
        checkOutput("rst_mid_noclr", 32'(clr4),  32'h0);
        // Pointer back at 0: 1001 must pick 0, not 3.
        serveFour(4'b1001, 4'b0001, 4'b0000);

`ifdef FUNCTION_ARBITER_TIMEOUT_EN
        // Watchdog: sets held exactly 8 GRANT cycles, then forced ack with sticky err.
        applyStimulus(4'b0001, 1'b0, 2'b00, 1'b0);
        checkOutput("to_sets_rise", 32'(sets4), 32'h1);
        repeat (7) applyStimulus(4'b0001, 1'b0, 2'b00, 1'b0);
        checkOutput("to_sets_8th",  32'(sets4), 32'h1);
        checkOutput("to_err_early", 32'(err4),  32'h0);
        applyStimulus(4'b0001, 1'b0, 2'b00, 1'b0);
        checkOutput("to_sets_drop", 32'(sets4), 32'h0);
        checkOutput("to_acks",      32'(acks4), 32'h1);
        checkOutput("to_err_set",   32'(err4),  32'h1);
        applyStimulus(4'b0000, 1'b0, 2'b00, 1'b0);
        checkOutput("to_clr",       32'(clr4),  32'h1);
        applyStimulus(4'b0000, 1'b0, 2'b00, 1'b0);
        checkOutput("to_busy_idle", 32'(busy4), 32'h0);
        checkOutput("to_err_hold",  32'(err4),  32'h1);
        serveFour(4'b0001, 4'b0001, 4'b0000);
        checkOutput("to_err_sticky", 32'(err4), 32'h1);
        rst = 1'b1;
        applyStimulus(4'b0000, 1'b0, 2'b00, 1'b0);
        checkOutput("to_err_rst",   32'(err4),  32'h0);
        rst = 1'b0;
`else
        // No watchdog: GRANT waits indefinitely, err stays 0.
        applyStimulus(4'b0001, 1'b0, 2'b00, 1'b0);
        checkOutput("nt_sets_rise", 32'(sets4), 32'h1);
        repeat (1000) applyStimulus(4'b0001, 1'b0, 2'b00, 1'b0);
        checkOutput("nt_sets_held", 32'(sets4), 32'h1);
        checkOutput("nt_acks_none", 32'(acks4), 32'h0);
        checkOutput("nt_err_zero",  32'(err4),  32'h0);
        applyStimulus(4'b0001, 1'b1, 2'b00, 1'b0);
        checkOutput("nt_acks",      32'(acks4), 32'h1);
        checkOutput("nt_sets_off",  32'(sets4), 32'h0);
        applyStimulus(4'b0000, 1'b0, 2'b00, 1'b0);
        checkOutput("nt_clr",       32'(clr4),  32'h1);
        applyStimulus(4'b0000, 1'b0, 2'b00, 1'b0);
        checkOutput("nt_busy_idle", 32'(busy4), 32'h0);
        checkOutput("nt_err_end",   32'(err4),  32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule

// File: doc/function_arbiter.md
# function_arbiter

Synchronous controller that shares one function unit (the one-hot `sets` / `fin` / clear style chooser datapath) among N requesters. Each requester runs a 4-phase req/ack handshake. The arbiter picks one requester round-robin and drives its one-hot `sets` line into the unit. It waits for the unit's `fin`, acknowledges the winner, then pulses `clr` to return the unit to idle before the next grant.

## Interface
Parameters:
- `N`, 2, number of requesters (≥2)
- `TIMEOUT`, 255, watchdog limit in cycles for `fin` (used only with the macro)

Ports:
- `clk` in 1: single clock
- `rst` in 1: reset, synchronous, active-high
- `reqs` in N: per-requester request, level, synchronous to `clk`
- `acks` out N: per-requester acknowledge, one-hot or zero
- `sets` out N: one-hot select into the function unit
- `fin` in 1: function unit done, level
- `clr` out 1: one-cycle clear pulse to the function unit
- `busy` out 1: high in every state except IDLE
- `err` out 1: sticky timeout flag (tied 0 without macro)

## Operation
- Reset: `acks`=0, `sets`=0, `clr`=0, `busy`=0, `err`=0, round-robin pointer `ptr`=0, state IDLE. Reset mid-operation abandons the transaction and does not pulse `clr`.
- Round-robin: the winner is the first set bit of `reqs` scanning from `ptr` upward, wrapping from N-1 to 0. After each completed transaction, `ptr` = (winner+1) mod N.
- States:
  - IDLE: if any `reqs` bit is high, latch winner and go to GRANT. `fin` is ignored in IDLE.
  - GRANT: `sets`=onehot(winner). Hold until `fin`=1, then `sets`→0, `acks[winner]`→1, go to ACK.
  - ACK: hold `acks[winner]` until `reqs[winner]`=0, then `acks`→0, go to CLEAR.
  - CLEAR: `clr`=1 for exactly one cycle, update `ptr`, go to IDLE.
- Requests from non-winners are held pending. They are never dropped, and no ack is given to them.
- A winner that drops `reqs` before `fin` still completes normally. `ack` asserts, then releases one cycle later.
- `fin` is sampled only in GRANT. A `fin` still high in CLEAR or IDLE is ignored. The unit must drop `fin` on `clr`.
- At most one `acks` bit and at most one `sets` bit is high at any time. `sets` and `acks` are never high together.

## Timing
- All outputs are registered.
- `reqs` high at cycle t in IDLE → `sets` high at t+1, `busy` high at t+1.
- `fin` high at t in GRANT → `sets` low and `acks[winner]` high at t+1.
- `reqs[winner]` low at t in ACK → `acks` low at t+1, `clr` high at t+1 only, IDLE at t+2.
- With a pending request, the next `sets` rises at t+3.
- Minimum transaction (req → ack with immediate `fin`): 2 cycles.

## Configuration
- `FUNCTION_ARBITER_TIMEOUT_EN` defined:
  - A counter (width clog2(TIMEOUT+1)) clears on entry to GRANT and increments each GRANT cycle.
  - On reaching `TIMEOUT` without `fin`: `sets`→0, `err`→1 (sticky until `rst`), `acks[winner]`→1, go to ACK. The transaction then completes normally with its `clr` pulse.
- Not defined: no counter. GRANT waits for `fin` indefinitely, and `err` is constant 0.

## Structure
- Package `function_arbiter_pkg`: state enum typedef (IDLE, GRANT, ACK, CLEAR), with the encoding as localparams shared with the bench.
- Sub-module `rr_picker`: combinational round-robin priority picker. Inputs are `reqs` and `ptr`; outputs are the one-hot winner and a `valid` flag. It is instantiated once.
- FSM, pointer, watchdog and output registers live in `function_arbiter`.

## Test plan
- N=2, reqs=01, `fin` returned 2 cycles after `sets`=01 → `acks`=01 one cycle after `fin`. Drop req → `clr` single pulse, `ptr`=1, `busy` low.
- N=4, reqs=1111 held, each served with `fin` → grant order 0,1,2,3,0. Never two `sets` bits high.
- N=4, `ptr`=3, reqs=0101 → winner 0 (wrap). `ptr` becomes 1 after CLEAR.
- `rst` asserted in ACK with `acks`=0010 → next cycle all outputs 0, `ptr`=0, no `clr` pulse.
- Macro on, TIMEOUT=8, `fin` never asserted → `sets` drops after 8 GRANT cycles, `err`=1, ack/clr sequence completes. `err` stays 1 until `rst`.
- Macro off, `fin` withheld for 1000 cycles → `sets` held, `err`=0. Then `fin`=1 → normal ack.
